host_bus_writer: RTL and testbench
==================================

HOST_BUS_WRITER -- requirements
Module: host_bus_writer

Interface
REQ-001 Parameter SETUP_CYCLES, default 1: cycles the address/data are driven before the strobe asserts (range 1-7).
REQ-002 Parameter STROBE_CYCLES, default 2: cycles the strobe is held low (range 1-7).
REQ-003 Parameter HOLD_CYCLES, default 1: cycles the address/data stay driven after the strobe deasserts (range 1-7).
REQ-004 clk  input  1  single system clock; all logic on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 reqValid  input  1  write request present.
REQ-007 reqAddr  input  13  target VRAM address; [12:11] bank, [10:0] in-bank offset.
REQ-008 reqData  input  8  byte to write.
REQ-009 reqReady  output  1  request accepted on a cycle where reqValid and reqReady are both high.
REQ-010 hostBusAddr  output  11  bus address.
REQ-011 hostBusData  output  8  bus write data.
REQ-012 hostBusOE  output  1  high while this block drives hostBusData.
REQ-013 nHostWMEM  output  1  active-low write strobe.
REQ-014 nHostVRAMEn  output  1  active-low VRAM select.
REQ-015 nHostBankRegEn  output  1  active-low bank register select.
REQ-016 busy  output  1  high when any bus cycle is in progress or any request is pending.

Function
REQ-017 The block SHALL be the bus initiator for host writes: every accepted request SHALL produce exactly one VRAM write cycle, in acceptance order.
REQ-018 The FSM SHALL have the states IDLE, SETUP, STROBE, HOLD and a cycle-kind flag BANK/VRAM, plus one phase counter of 3 bits.
REQ-019 IDLE -> SETUP when a request is pending; SETUP -> STROBE after SETUP_CYCLES; STROBE -> HOLD after STROBE_CYCLES; HOLD -> IDLE, or directly to SETUP when another cycle is pending, after HOLD_CYCLES.
REQ-020 The block SHALL track curBank (2 bits) and bankValid; a BANK cycle SHALL precede the VRAM cycle when bankValid is 0 or reqAddr[12:11] differs from curBank.
REQ-021 BANK cycle: hostBusAddr SHALL be 0, hostBusData SHALL be {6'b0, bank}, and nHostBankRegEn SHALL be low in SETUP, STROBE and HOLD; curBank and bankValid SHALL update at the end of HOLD.
REQ-022 VRAM cycle: hostBusAddr SHALL be reqAddr[10:0], hostBusData SHALL be reqData, and nHostVRAMEn SHALL be low in SETUP, STROBE and HOLD.
REQ-023 nHostWMEM SHALL be low only in STROBE; hostBusOE SHALL be high in SETUP, STROBE and HOLD.
REQ-024 Address, data and select outputs SHALL be stable for the whole of a cycle.
REQ-025 nHostBankRegEn and nHostVRAMEn SHALL never both be low.
REQ-026 All outputs SHALL be registered, with no combinational path from request inputs to bus outputs.
REQ-027 Minimum VRAM cycle length SHALL be SETUP_CYCLES+STROBE_CYCLES+HOLD_CYCLES clocks; a bank change SHALL add one further such cycle.
REQ-028 Back-to-back requests in the same bank SHALL produce no idle cycle between HOLD and the next SETUP.

Reset
REQ-029 While rst is high: the FSM SHALL be in IDLE, and nHostWMEM, nHostVRAMEn and nHostBankRegEn SHALL be 1.
REQ-030 While rst is high: hostBusOE, busy, reqReady and bankValid SHALL be 0, and hostBusAddr, hostBusData and curBank SHALL be 0.
REQ-031 Reset asserted mid-cycle SHALL deassert all strobes and selects asynchronously and discard all pending requests.
REQ-032 reqReady SHALL rise on the first clock after rst deasserts.

Configuration
REQ-033 With HOST_WRITER_FIFO_EN defined, requests SHALL pass through a 4-entry FIFO; reqReady SHALL be high whenever the FIFO is not full.
REQ-034 With HOST_WRITER_FIFO_EN defined, a request accepted on the same cycle as a pop from a full FIFO SHALL be accepted.
REQ-035 Without HOST_WRITER_FIFO_EN, a single holding register SHALL be used; reqReady SHALL be high only in IDLE with the register empty.

Structure
REQ-036 A shared package SHALL hold the FSM state typedef, the bank-register address constant (0) and the bank/offset field widths (2/11).
REQ-037 The FIFO SHALL be a sub-module named host_req_fifo, instantiated only when HOST_WRITER_FIFO_EN is defined.

Verification
REQ-038 After reset, write 0x41 to 0x0005 -> BANK cycle with data 0x00, then VRAM cycle addr 0x005 data 0x41; nHostWMEM low 2 clocks each; 8 clocks total.
REQ-039 Write 0x0010 then 0x0011 (bank 0 already valid) -> two VRAM cycles only, no idle cycle between them.
REQ-040 Write 0x1805 data 0x7E -> BANK cycle with data 0x03, then VRAM cycle addr 0x005 data 0x7E.
REQ-041 With FIFO enabled, 6 requests with reqValid held high -> reqReady drops after the 4th accept and 6 cycles emerge in order.
REQ-042 Assert rst during STROBE -> nHostWMEM and the selects go high the same cycle; after release, the next request performs a BANK cycle first.
REQ-043 Random request stream -> a checker asserts the REQ-025 mutual exclusion and setup/strobe/hold counts on every cycle.

Source files
------------

// File: rtl/host_bus_writer_pkg.sv
// Shared types and constants for the host bus write initiator.
package host_bus_writer_pkg;

   localparam int BANK_W   = 2;
   localparam int OFFSET_W = 11;
   localparam int ADDR_W   = BANK_W + OFFSET_W;
   localparam int DATA_W   = 8;

   // Writing the bank number to this bus address selects the VRAM bank.
   localparam logic [OFFSET_W-1:0] BANK_REG_ADDR = '0;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETUP,
      ST_STROBE,
      ST_HOLD
   } state_t;

   typedef enum logic {
      KIND_BANK,
      KIND_VRAM
   } kind_t;

   function automatic logic [BANK_W-1:0] bank_of(input logic [ADDR_W-1:0] addr);
      return addr[ADDR_W-1:OFFSET_W];
   endfunction

endpackage

// File: rtl/host_req_fifo.sv
// Four-entry request FIFO with a look-ahead port on the entry behind the head,
// so the writer can chain the next cycle without an idle clock.
module host_req_fifo
   import host_bus_writer_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [ADDR_W-1:0] push_addr,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic              full,
   output logic              head_valid,
   output logic [ADDR_W-1:0] head_addr,
   output logic [DATA_W-1:0] head_data,
   output logic              next_valid,
   output logic [ADDR_W-1:0] next_addr,
   output logic [DATA_W-1:0] next_data
);

   localparam int DEPTH = 4;

   logic [ADDR_W+DATA_W-1:0] mem [DEPTH];
   logic [1:0] rd_ptr_reg;
   logic [1:0] wr_ptr_reg;
   logic [1:0] rd_ptr_plus;
   logic [2:0] count_reg;

   assign rd_ptr_plus = rd_ptr_reg + 2'd1;
   assign full        = (count_reg == 3'd4);
   assign head_valid  = (count_reg != 3'd0);
   assign next_valid  = (count_reg >= 3'd2);
   assign {head_addr, head_data} = mem[rd_ptr_reg];
   assign {next_addr, next_data} = mem[rd_ptr_plus];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr_reg <= '0;
         wr_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push) wr_ptr_reg <= wr_ptr_reg + 2'd1;
         if (pop)  rd_ptr_reg <= rd_ptr_plus;
         count_reg <= count_reg + {2'b00, push} - {2'b00, pop};
      end
   end

   // A push into a full FIFO only happens alongside a pop, so the slot is free.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_reg] <= {push_addr, push_data};
   end

endmodule

// File: rtl/host_bus_writer.sv
// Host write initiator: turns requests into BANK/VRAM bus cycles with fixed setup/strobe/hold.
// Define HOST_WRITER_FIFO_EN to buffer requests in a 4-entry FIFO instead of one holding register.
module host_bus_writer
   import host_bus_writer_pkg::*;
#(
   parameter int SETUP_CYCLES  = 1,
   parameter int STROBE_CYCLES = 2,
   parameter int HOLD_CYCLES   = 1
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        reqValid,
   input  logic [12:0] reqAddr,
   input  logic [7:0]  reqData,
   output logic        reqReady,
   output logic [10:0] hostBusAddr,
   output logic [7:0]  hostBusData,
   output logic        hostBusOE,
   output logic        nHostWMEM,
   output logic        nHostVRAMEn,
   output logic        nHostBankRegEn,
   output logic        busy
);

   localparam logic [2:0] SETUP_LAST  = 3'(SETUP_CYCLES - 1);
   localparam logic [2:0] STROBE_LAST = 3'(STROBE_CYCLES - 1);
   localparam logic [2:0] HOLD_LAST   = 3'(HOLD_CYCLES - 1);

   state_t             state_reg, state_next;
   kind_t              kind_reg, kind_next, start_kind;
   logic [2:0]         phase_reg, phase_next;
   logic [BANK_W-1:0]  cur_bank_reg;
   logic               bank_valid_reg;

   logic               head_valid, next_valid, push, pop;
   logic [ADDR_W-1:0]  head_addr, next_addr, start_addr;
   logic [DATA_W-1:0]  head_data, next_data, start_data;
   logic               head_needs_bank, next_needs_bank;
   logic               start, bank_done, pending_next;

`ifdef HOST_WRITER_FIFO_EN
   logic full;
   logic ready_en_reg;

   host_req_fifo u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (push),
      .push_addr  (reqAddr),
      .push_data  (reqData),
      .pop        (pop),
      .full       (full),
      .head_valid (head_valid),
      .head_addr  (head_addr),
      .head_data  (head_data),
      .next_valid (next_valid),
      .next_addr  (next_addr),
      .next_data  (next_data)
   );

   // Held low through the first clock after reset release.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) ready_en_reg <= 1'b0;
      else     ready_en_reg <= 1'b1;
   end

   // pop comes only from registered state, so this has no path from the request inputs.
   assign reqReady = ready_en_reg && (!full || pop);
`else
   logic              hold_valid_reg, hold_valid_next, ready_reg;
   logic [ADDR_W-1:0] hold_addr_reg;
   logic [DATA_W-1:0] hold_data_reg;

   assign hold_valid_next = push || (hold_valid_reg && !pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_valid_reg <= 1'b0;
         hold_addr_reg  <= '0;
         hold_data_reg  <= '0;
         ready_reg      <= 1'b0;
      end else begin
         hold_valid_reg <= hold_valid_next;
         if (push) begin
            hold_addr_reg <= reqAddr;
            hold_data_reg <= reqData;
         end
         ready_reg <= (state_next == ST_IDLE) && !hold_valid_next;
      end
   end

   assign reqReady   = ready_reg;
   assign head_valid = hold_valid_reg;
   assign head_addr  = hold_addr_reg;
   assign head_data  = hold_data_reg;
   assign next_valid = 1'b0;
   assign next_addr  = '0;
   assign next_data  = '0;
`endif

   assign push            = reqValid && reqReady;
   assign pending_next    = push || next_valid || (head_valid && !pop);
   assign head_needs_bank = !bank_valid_reg || (bank_of(head_addr) != cur_bank_reg);
   assign next_needs_bank = !bank_valid_reg || (bank_of(next_addr) != cur_bank_reg);

   always_comb begin
      state_next = state_reg;
      kind_next  = kind_reg;
      phase_next = phase_reg;
      start      = 1'b0;
      start_kind = KIND_VRAM;
      start_addr = head_addr;
      start_data = head_data;
      bank_done  = 1'b0;
      pop        = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (head_valid) begin
               start      = 1'b1;
               start_kind = head_needs_bank ? KIND_BANK : KIND_VRAM;
            end
         end
         ST_SETUP: begin
            if (phase_reg == SETUP_LAST) begin
               state_next = ST_STROBE;
               phase_next = 3'd0;
            end else begin
               phase_next = phase_reg + 3'd1;
            end
         end
         ST_STROBE: begin
            if (phase_reg == STROBE_LAST) begin
               state_next = ST_HOLD;
               phase_next = 3'd0;
            end else begin
               phase_next = phase_reg + 3'd1;
            end
         end
         ST_HOLD: begin
            if (phase_reg != HOLD_LAST) begin
               phase_next = phase_reg + 3'd1;
            end else if (kind_reg == KIND_BANK) begin
               // Bank register written; the same head request now gets its VRAM cycle.
               bank_done = 1'b1;
               start     = 1'b1;
            end else begin
               pop        = 1'b1;
               state_next = ST_IDLE;
               if (next_valid) begin
                  start      = 1'b1;
                  start_addr = next_addr;
                  start_data = next_data;
                  start_kind = next_needs_bank ? KIND_BANK : KIND_VRAM;
               end
            end
         end
         default: state_next = ST_IDLE;
      endcase
      if (start) begin
         state_next = ST_SETUP;
         phase_next = 3'd0;
         kind_next  = start_kind;
      end
   end

   // Bus outputs are registered from the next-state decode so they line up with state_reg.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg      <= ST_IDLE;
         kind_reg       <= KIND_VRAM;
         phase_reg      <= 3'd0;
         cur_bank_reg   <= '0;
         bank_valid_reg <= 1'b0;
         hostBusAddr    <= '0;
         hostBusData    <= '0;
         hostBusOE      <= 1'b0;
         nHostWMEM      <= 1'b1;
         nHostVRAMEn    <= 1'b1;
         nHostBankRegEn <= 1'b1;
         busy           <= 1'b0;
      end else begin
         state_reg <= state_next;
         kind_reg  <= kind_next;
         phase_reg <= phase_next;
         if (bank_done) begin
            cur_bank_reg   <= hostBusData[BANK_W-1:0];
            bank_valid_reg <= 1'b1;
         end
         if (start) begin
            hostBusAddr <= (start_kind == KIND_BANK) ? BANK_REG_ADDR : start_addr[OFFSET_W-1:0];
            hostBusData <= (start_kind == KIND_BANK) ?
                           {{(DATA_W-BANK_W){1'b0}}, bank_of(start_addr)} : start_data;
         end
         hostBusOE      <= (state_next != ST_IDLE);
         nHostWMEM      <= (state_next != ST_STROBE);
         nHostVRAMEn    <= !((state_next != ST_IDLE) && (kind_next == KIND_VRAM));
         nHostBankRegEn <= !((state_next != ST_IDLE) && (kind_next == KIND_BANK));
         busy           <= (state_next != ST_IDLE) || pending_next;
      end
   end

endmodule

// File: tb/tb_host_bus_writer.sv
// Directed + random bench for host_bus_writer; a bus monitor pops expected cycles from a scoreboard.
// FIFO-only steps are compiled when HOST_WRITER_FIFO_EN is defined.
module tb_host_bus_writer;

   localparam int SETUP_CYCLES  = 1;
   localparam int STROBE_CYCLES = 2;
   localparam int HOLD_CYCLES   = 1;
   localparam int BOUND         = 400;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        reqValid = 1'b0;
   logic [12:0] reqAddr = '0;
   logic [7:0]  reqData = '0;
   logic        reqReady, hostBusOE, nHostWMEM, nHostVRAMEn, nHostBankRegEn, busy;
   logic [10:0] hostBusAddr;
   logic [7:0]  hostBusData;

   int checks = 0;
   int failures = 0;

   typedef struct packed {
      logic        bank;
      logic [10:0] addr;
      logic [7:0]  data;
   } exp_t;

   exp_t       sb[$];
   int         gap_q[$];
   logic       m_bank_valid = 1'b0;
   logic [1:0] m_bank = 2'd0;

   host_bus_writer #(
      .SETUP_CYCLES  (SETUP_CYCLES),
      .STROBE_CYCLES (STROBE_CYCLES),
      .HOLD_CYCLES   (HOLD_CYCLES)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .reqValid       (reqValid),
      .reqAddr        (reqAddr),
      .reqData        (reqData),
      .reqReady       (reqReady),
      .hostBusAddr    (hostBusAddr),
      .hostBusData    (hostBusData),
      .hostBusOE      (hostBusOE),
      .nHostWMEM      (nHostWMEM),
      .nHostVRAMEn    (nHostVRAMEn),
      .nHostBankRegEn (nHostBankRegEn),
      .busy           (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Reference behaviour: a bank write precedes any write whose bank is not the latched one.
   task automatic expect_write(input logic [12:0] a, input logic [7:0] d);
      if (!m_bank_valid || a[12:11] != m_bank) begin
         sb.push_back(exp_t'{1'b1, 11'd0, {6'd0, a[12:11]}});
         m_bank       = a[12:11];
         m_bank_valid = 1'b1;
      end
      sb.push_back(exp_t'{1'b0, a[10:0], d});
   endtask

   task automatic send(input logic [12:0] a, input logic [7:0] d, input bit keep);
      int n = 0;
      reqAddr  = a;
      reqData  = d;
      reqValid = 1'b1;
      while (!reqReady && n < BOUND) begin
         @(negedge clk);
         n++;
      end
      check("accept_timeout", {31'd0, n >= BOUND}, 32'd0);
      if (n < BOUND) begin
         @(posedge clk);
         #1;
         $display("tb: request addr=0x%04h data=0x%02h accepted at %0t", a, d, $time);
         expect_write(a, d);
      end
      if (!keep) reqValid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((sb.size() != 0 || busy) && n < BOUND) begin
         @(negedge clk);
         n++;
      end
      check("drain_scoreboard", sb.size(), 0);
      check("drain_busy", {31'd0, busy}, 32'd0);
   endtask

   // ---------------- bus monitor ----------------
   typedef enum {M_IDLE, M_SETUP, M_STROBE, M_HOLD} mon_t;
   mon_t        mph = M_IDLE;
   int          mcnt = 0;
   int          idle_cnt = 0;
   logic        cyc_bank;
   logic [10:0] cyc_addr;
   logic [7:0]  cyc_data;

   task automatic stable();
      check("oe_active", {31'd0, hostBusOE}, 32'd1);
      check("addr_stable", {21'd0, hostBusAddr}, {21'd0, cyc_addr});
      check("data_stable", {24'd0, hostBusData}, {24'd0, cyc_data});
      check("sel_stable", {30'd0, nHostBankRegEn, nHostVRAMEn}, {30'd0, !cyc_bank, cyc_bank});
   endtask

   task automatic finish_cycle();
      exp_t e;
      checks++;
      assert (sb.size() > 0) else begin
         failures++;
         $error("FAIL unexpected_cycle observed=bank:%0d addr=0x%03h data=0x%02h expected=none",
                cyc_bank, cyc_addr, cyc_data);
      end
      if (sb.size() > 0) begin
         e = sb.pop_front();
         $display("tb: cycle %s addr=0x%03h data=0x%02h done at %0t",
                  cyc_bank ? "BANK" : "VRAM", cyc_addr, cyc_data, $time);
         check("cyc_kind", {31'd0, cyc_bank}, {31'd0, e.bank});
         check("cyc_addr", {21'd0, cyc_addr}, {21'd0, e.addr});
         check("cyc_data", {24'd0, cyc_data}, {24'd0, e.data});
      end
   endtask

   always @(negedge clk) begin
      if (rst) begin
         mph      = M_IDLE;
         mcnt     = 0;
         idle_cnt = 0;
      end else begin
         check("sel_mutex", {31'd0, !nHostVRAMEn && !nHostBankRegEn}, 32'd0);
         if (mph == M_HOLD && mcnt == HOLD_CYCLES) begin
            finish_cycle();
            mph = M_IDLE;
         end
         case (mph)
            M_IDLE: begin
               if (hostBusOE) begin
                  check("setup_wmem", {31'd0, nHostWMEM}, 32'd1);
                  check("sel_onehot", {31'd0, nHostVRAMEn ^ nHostBankRegEn}, 32'd1);
                  cyc_bank = !nHostBankRegEn;
                  cyc_addr = hostBusAddr;
                  cyc_data = hostBusData;
                  gap_q.push_back(idle_cnt);
                  idle_cnt = 0;
                  mph  = M_SETUP;
                  mcnt = 1;
               end else begin
                  check("idle_strobes", {29'd0, nHostWMEM, nHostVRAMEn, nHostBankRegEn}, 32'd7);
                  idle_cnt++;
               end
            end
            M_SETUP: begin
               stable();
               if (!nHostWMEM) begin
                  check("setup_len", mcnt, SETUP_CYCLES);
                  mph  = M_STROBE;
                  mcnt = 1;
               end else begin
                  mcnt++;
               end
            end
            M_STROBE: begin
               stable();
               if (nHostWMEM) begin
                  check("strobe_len", mcnt, STROBE_CYCLES);
                  mph  = M_HOLD;
                  mcnt = 1;
               end else begin
                  mcnt++;
               end
            end
            M_HOLD: begin
               stable();
               check("hold_wmem", {31'd0, nHostWMEM}, 32'd1);
               mcnt++;
            end
            default: mph = M_IDLE;
         endcase
      end
   end

   // ---------------- directed sequence ----------------
   initial begin
      int k;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_addr", {21'd0, hostBusAddr}, 32'd0);
      check("rst_data", {24'd0, hostBusData}, 32'd0);
      check("rst_oe", {31'd0, hostBusOE}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_ready", {31'd0, reqReady}, 32'd0);
      check("rst_strobes", {29'd0, nHostWMEM, nHostVRAMEn, nHostBankRegEn}, 32'd7);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("ready_before_clk", {31'd0, reqReady}, 32'd0);
      @(posedge clk);
      #1;
      check("ready_first_clk", {31'd0, reqReady}, 32'd1);

      // First write after reset: bank write then VRAM write, back to back (8 clocks).
      gap_q.delete();
      send(13'h0005, 8'h41, 1'b0);
      check("busy_active", {31'd0, busy}, 32'd1);
      drain();
      check("t1_cycle_count", gap_q.size(), 2);
      if (gap_q.size() == 2) check("t1_bank_vram_gap", gap_q[1], 0);

      // Same bank twice: no bank cycle.
      gap_q.delete();
      send(13'h0010, 8'hA5, 1'b0);
      send(13'h0011, 8'h5A, 1'b0);
      drain();
      check("t2_cycle_count", gap_q.size(), 2);
`ifdef HOST_WRITER_FIFO_EN
      if (gap_q.size() == 2) check("t2_no_idle_gap", gap_q[1], 0);
`endif

      // Bank change to bank 3.
      gap_q.delete();
      send(13'h1805, 8'h7E, 1'b0);
      drain();
      check("t3_cycle_count", gap_q.size(), 2);

`ifdef HOST_WRITER_FIFO_EN
      // Six requests with reqValid held: ready drops once four are queued.
      gap_q.delete();
      for (int i = 0; i < 6; i++) begin
         send(13'h1820 + 13'(i), 8'h10 + 8'(i), i != 5);
         if (i == 3) check("fifo_full_ready", {31'd0, reqReady}, 32'd0);
      end
      drain();
      check("fifo_cycle_count", gap_q.size(), 6);
`endif

      // Reset during a strobe aborts the cycle and forgets the bank.
      send(13'h1000, 8'h99, 1'b0);
      k = 0;
      while (nHostWMEM && k < BOUND) begin
         @(negedge clk);
         k++;
      end
      check("strobe_seen", {31'd0, nHostWMEM}, 32'd0);
      #2 rst = 1'b1;
      #1;
      check("async_rst_strobes", {29'd0, nHostWMEM, nHostVRAMEn, nHostBankRegEn}, 32'd7);
      check("async_rst_oe", {31'd0, hostBusOE}, 32'd0);
      check("async_rst_busy", {31'd0, busy}, 32'd0);
      sb.delete();
      m_bank_valid = 1'b0;
      m_bank       = 2'd0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      gap_q.delete();
      send(13'h1000, 8'h55, 1'b0);
      drain();
      check("post_rst_cycle_count", gap_q.size(), 2);

      // Random stream; the monitor checks exclusion and phase lengths every cycle.
      for (int i = 0; i < 20; i++) begin
         send(13'($urandom_range(0, 8191)), 8'($urandom_range(0, 255)), 1'b0);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      drain();
      repeat (10) @(negedge clk);
      check("final_scoreboard", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
